// File: rtl/reaction_timer_core.sv
// Reaction-time core: random/fixed fore-period, GO indicator, 4-digit BCD millisecond count.
// Optional feature macro RANDOM_DELAY_EN adds an LFSR-based extension to the fore-period.
module reaction_timer_core #(
    parameter int unsigned WAIT_MIN_MS = 1000,
    parameter int unsigned RAND_MASK   = 1023,
    parameter logic [9:0]  LFSR_SEED   = 10'h2A5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1ms,
    input  logic        start,
    input  logic        resp,
    output logic        tick_en,
    output logic        go_led,
    output logic [15:0] bcd_ms,
    output logic        valid,
    output logic        early,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [12:0] WAIT_MIN  = 13'(WAIT_MIN_MS);
    localparam logic [15:0] BCD_LIMIT = 16'h9999;

    // Reject parameter sets the 13-bit delay counter or the LFSR cannot honour.
    if (WAIT_MIN_MS < 1 || WAIT_MIN_MS > 4095 || WAIT_MIN_MS + RAND_MASK > 8191 ||
        ((RAND_MASK + 1) & RAND_MASK) != 0 || LFSR_SEED == 10'd0) begin : g_bad_cfg
        $error("reaction_timer_core: invalid parameter set");
    end

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [12:0] delay_load;

`ifdef RANDOM_DELAY_EN
    logic [9:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
        end
    end

    assign delay_load = WAIT_MIN + 13'(lfsr & 10'(RAND_MASK));
`else
    assign delay_load = WAIT_MIN;
`endif

    // Stage p0 captures the inputs, p1 holds the previous sample for edge detection.
    logic start_p0, start_p1, resp_p0, resp_p1;
    logic start_edge, resp_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_p0 <= 1'b0;
            start_p1 <= 1'b0;
            resp_p0  <= 1'b0;
            resp_p1  <= 1'b0;
        end else begin
            start_p0 <= start;
            start_p1 <= start_p0;
            resp_p0  <= resp;
            resp_p1  <= resp_p0;
        end
    end

    assign start_edge = start_p0 & ~start_p1;
    assign resp_edge  = resp_p0 & ~resp_p1;

    state_t      state, state_next;
    logic [12:0] delay, delay_next;
    logic [15:0] bcd, bcd_next;
    logic        valid_r, valid_next;
    logic        early_r, early_next;
    logic        timeout_r, timeout_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            delay     <= 13'd0;
            bcd       <= 16'h0000;
            valid_r   <= 1'b0;
            early_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state     <= state_next;
            delay     <= delay_next;
            bcd       <= bcd_next;
            valid_r   <= valid_next;
            early_r   <= early_next;
            timeout_r <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state;
        delay_next   = delay;
        bcd_next     = bcd;
        valid_next   = valid_r;
        early_next   = early_r;
        timeout_next = timeout_r;
        case (state)
            S_IDLE, S_DONE, S_FAULT: begin
                if (start_edge) begin
                    state_next   = S_WAIT;
                    delay_next   = delay_load;
                    bcd_next     = 16'h0000;
                    valid_next   = 1'b0;
                    early_next   = 1'b0;
                    timeout_next = 1'b0;
                end
            end
            S_WAIT: begin
                // A response during the fore-period beats a coincident tick.
                if (resp_edge) begin
                    state_next = S_FAULT;
                    early_next = 1'b1;
                end else if (tick_1ms) begin
                    if (delay <= 13'd1) begin
                        state_next = S_GO;
                        delay_next = 13'd0;
                    end else begin
                        delay_next = delay - 13'd1;
                    end
                end
            end
            S_GO: begin
                if (resp_edge) begin
                    state_next = S_DONE;
                    valid_next = 1'b1;
                end else if (tick_1ms) begin
                    if (bcd == BCD_LIMIT) begin
                        state_next   = S_FAULT;
                        timeout_next = 1'b1;
                    end else begin
                        bcd_next = bcd_inc(bcd);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign tick_en = (state == S_WAIT) || (state == S_GO);
    assign go_led  = (state == S_GO);
    assign bcd_ms  = bcd;
    assign valid   = valid_r;
    assign early   = early_r;
    assign timeout = timeout_r;

endmodule
